// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// 8 lines of 4-byte blocks. The CPU side is byte-wide and the memory side is block-wide.
// Address layout: [7:5] tag, [4:2] index, [1:0] byte offset.
module data_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q [8];
  logic [2:0]  tag_q  [8];
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;

  logic [2:0]  addr_tag;
  logic [2:0]  index;
  logic [1:0]  offset;
  logic [31:0] line_data;
  logic        hit;
  logic        req;
  logic        write_hit;
  logic        fetch_done;

  assign addr_tag  = ADDRESS[7:5];
  assign index     = ADDRESS[4:2];
  assign offset    = ADDRESS[1:0];
  assign line_data = data_q[index];
  assign hit       = valid_q[index] && (tag_q[index] == addr_tag);
  assign req       = READ || WRITE;
  // A simultaneous READ and WRITE is handled as a write.
  assign write_hit  = (state_q == StIdle) && WRITE && hit;
  assign fetch_done = (state_q == StFetch) && !MEM_BUSYWAIT;

  // Selected byte of the indexed line; meaningful only on a read hit.
  assign READDATA = line_data[{offset, 3'b000} +: 8];

  // State register plus valid/dirty bits; reset aborts any memory transfer in flight.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (write_hit) begin
        dirty_q[index] <= 1'b1;
      end
      if (fetch_done) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // Line data and tags carry no reset; updates are suppressed while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (write_hit) begin
        data_q[index][{offset, 3'b000} +: 8] <= WRITEDATA;
      end
      if (fetch_done) begin
        data_q[index] <= MEM_READDATA;
        tag_q[index]  <= addr_tag;
      end
    end
  end

  // Next-state and memory/CPU handshake outputs, decoded from the current state.
  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = ADDRESS[7:2];
    MEM_WRITEDATA = line_data;
    unique case (state_q)
      StIdle: begin
        BUSYWAIT = req && !hit;
        if (req && !hit) begin
          if (valid_q[index] && dirty_q[index]) begin
            state_d = StWriteback;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StWriteback: begin
        BUSYWAIT    = 1'b1;
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_q[index], index};
        if (!MEM_BUSYWAIT) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios followed by random loads and stores.
// Expected values come from a flat byte-array view of memory and a per-line tag model.
module tb_data_cache;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          passed = 0;
  int          total  = 0;
  int unsigned lat    = 2;

  // Backing memory, and the byte-level memory contents the CPU should observe.
  logic [31:0] mem_blk [64];
  logic [7:0]  ref_mem [256];
  // Which block each line should hold.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];

  // Memory: each request holds MEM_BUSYWAIT high for lat-1 cycles, then completes.
  int unsigned mcnt  = 0;
  logic [1:0]  mkind = 2'b00;
  initial MEM_BUSYWAIT = 1'b0;
  initial MEM_READDATA = '0;
  always @(negedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if ({MEM_READ, MEM_WRITE} != mkind) mcnt = 1;
      else mcnt = mcnt + 1;
      mkind        = {MEM_READ, MEM_WRITE};
      MEM_BUSYWAIT = (mcnt < lat);
      if (MEM_WRITE && !MEM_BUSYWAIT) mem_blk[MEM_ADDRESS] = MEM_WRITEDATA;
    end else begin
      mcnt         = 0;
      mkind        = 2'b00;
      MEM_BUSYWAIT = 1'b0;
    end
    MEM_READDATA = mem_blk[MEM_ADDRESS];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sync_ref_from_mem();
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) ref_mem[b*4+k] = mem_blk[b][k*8 +: 8];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // One CPU access from the cycle it is presented until BUSYWAIT drops.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int unsigned l);
    logic [2:0]  idx;
    logic [5:0]  vblk;
    logic [31:0] victim;
    bit          exp_hit, exp_wb, saw_wb, saw_rd, both, done;
    int unsigned exp_stall, stall;
    idx     = a[4:2];
    exp_hit = m_valid[idx] && (m_tag[idx] == a[7:5]);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    vblk    = {m_tag[idx], idx};
    victim  = {ref_mem[{vblk, 2'd3}], ref_mem[{vblk, 2'd2}],
               ref_mem[{vblk, 2'd1}], ref_mem[{vblk, 2'd0}]};
    exp_stall = exp_hit ? 0 : (1 + l + (exp_wb ? l : 0));
    lat = l;
    @(posedge CLK);
    #1;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    stall = 0; saw_wb = 0; saw_rd = 0; both = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (MEM_READ && MEM_WRITE) both = 1;
      if (BUSYWAIT) begin
        stall++;
        if (MEM_WRITE && !saw_wb) begin
          saw_wb = 1;
          chk("wb_addr", {26'd0, MEM_ADDRESS}, {26'd0, vblk});
          chk("wb_data", MEM_WRITEDATA, victim);
        end
        if (MEM_READ && !saw_rd) begin
          saw_rd = 1;
          chk("fetch_addr", {26'd0, MEM_ADDRESS}, {26'd0, a[7:2]});
        end
      end else begin
        done = 1;
      end
    end
    chk("completed", {31'd0, done}, 32'd1);
    chk("stall_cycles", stall, exp_stall);
    chk("wb_seen", {31'd0, saw_wb}, {31'd0, exp_wb});
    chk("fetch_seen", {31'd0, saw_rd}, {31'd0, !exp_hit});
    chk("mem_rw_exclusive", {31'd0, both}, 32'd0);
    if (rd && !wr) chk("readdata", {24'd0, READDATA}, {24'd0, ref_mem[a]});
    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[7:5];
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      ref_mem[a]   = d;
    end
  endtask

  initial begin
    READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0; RESET = 0;
    for (int b = 0; b < 64; b++) mem_blk[b] = $urandom;
    mem_blk[1] = 32'hDDCCBBAA;
    sync_ref_from_mem();
    clear_model();

    // Reset state with no request pending.
    repeat (2) @(posedge CLK);
    #1 RESET = 1;
    @(negedge CLK);
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);

    // Cold read, hit, write hit, dirty conflict, dirty/clean conflicts.
    access(1, 0, 8'h05, 8'h00, 2);
    chk("cold_read_bb", {24'd0, READDATA}, 32'h000000BB);
    access(1, 0, 8'h07, 8'h00, 2);
    chk("hit_read_dd", {24'd0, READDATA}, 32'h000000DD);
    access(0, 1, 8'h04, 8'h5A, 2);
    access(1, 0, 8'h04, 8'h00, 2);
    chk("write_hit_5a", {24'd0, READDATA}, 32'h0000005A);
    access(0, 1, 8'h24, 8'h77, 2);
    chk("wb_committed", mem_blk[1], 32'hDDCCBB5A);
    access(1, 0, 8'h04, 8'h00, 3);
    chk("refetch_5a", {24'd0, READDATA}, 32'h0000005A);
    access(1, 0, 8'h44, 8'h00, 1);

    // Reset during FETCH: request drops, line stays invalid.
    lat = 3;
    @(posedge CLK);
    #1 READ = 1; WRITE = 0; ADDRESS = 8'h80;
    @(posedge CLK);
    @(negedge CLK);
    chk("fetch_active", {31'd0, MEM_READ}, 32'd1);
    RESET = 0;
    @(negedge CLK);
    chk("rst_fetch_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_fetch_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_fetch_busy_miss", {31'd0, BUSYWAIT}, 32'd1);
    READ = 0;
    RESET = 1;
    clear_model();
    sync_ref_from_mem();
    access(1, 0, 8'h80, 8'h00, 2);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      op = $urandom_range(0, 3);
      access(op != 1, op == 1 || op == 2, 8'($urandom), 8'($urandom), $urandom_range(1, 3));
    end

    @(posedge CLK);
    #1 READ = 0; WRITE = 0;
    @(negedge CLK);
    chk("final_idle", {31'd0, BUSYWAIT}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
